// File: rtl/proc_mem_pkg.sv
// Shared types and constants for the processor memory responder.
package proc_mem_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned MEM_DEPTH_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/be_byte_mem.sv
// Byte-wide store with three combinational big-endian word read ports and
// one big-endian word write port; byte addresses wrap modulo DEPTH.
module be_byte_mem
    import proc_mem_pkg::*;
#(
    parameter int unsigned DEPTH = MEM_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                we,
    input  logic [WORD_W-1:0]   waddr,
    input  logic [WORD_W-1:0]   wdata,
    input  logic [WORD_W-1:0]   raddr0,
    input  logic [WORD_W-1:0]   raddr1,
    input  logic [WORD_W-1:0]   raddr2,
    output logic [WORD_W-1:0]   rdata0,
    output logic [WORD_W-1:0]   rdata1,
    output logic [WORD_W-1:0]   rdata2
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];

    // Assemble each read word from four consecutive (wrapping) bytes, MSB first
    always_comb begin
        rdata0 = '0;
        rdata1 = '0;
        rdata2 = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            rdata0[31-8*k -: 8] = mem_q[raddr0[AW-1:0] + AW'(k)];
            rdata1[31-8*k -: 8] = mem_q[raddr1[AW-1:0] + AW'(k)];
            rdata2[31-8*k -: 8] = mem_q[raddr2[AW-1:0] + AW'(k)];
        end
    end

    // Word write scattered over four wrapping byte locations; contents never reset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned k = 0; k < 4; k++) begin
                mem_q[waddr[AW-1:0] + AW'(k)] <= wdata[31-8*k -: 8];
            end
        end
    end

endmodule

// File: rtl/proc_mem_responder.sv
// Memory-side responder and run sequencer for the single-cycle processor.
// Optional feature macro: PROC_MEM_TIMEOUT_EN adds the cycle watchdog;
// without it the run ends only on the NOP count and timed_out is tied 0.
module proc_mem_responder
    import proc_mem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = MEM_DEPTH_DEF,
    parameter int unsigned DUMP_WORDS = 22,
    parameter int unsigned NOP_LIMIT  = 9,
    parameter int unsigned TIMEOUT    = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        im_we,
    input  logic [31:0] im_addr,
    input  logic [31:0] im_wdata,
    output logic        proc_rst_n,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    input  logic        data_wr,
    output logic [31:0] data_in,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [31:0] dump_addr,
    output logic [31:0] dump_data,
    output logic        done,
    output logic        timed_out
);

    localparam int unsigned NOP_W = $clog2(NOP_LIMIT + 1);

    state_e           state_q, state_d;
    logic [NOP_W-1:0] nop_q, nop_d, nop_nxt;
    logic [29:0]      idx_q, idx_d;
    logic             proc_rst_n_q, proc_rst_n_d;
    logic             im_wr_en;
    logic             dm_wr_en;

`ifdef PROC_MEM_TIMEOUT_EN
    localparam int unsigned CYC_W = $clog2(TIMEOUT + 1);
    logic [CYC_W-1:0] cyc_q, cyc_d, cyc_nxt;
    logic             timed_out_q, timed_out_d;
`endif

    // Next-state, counters and dump index
    always_comb begin
        state_d = state_q;
        nop_d   = nop_q;
        idx_d   = idx_q;
        nop_nxt = nop_q + NOP_W'(inst == 32'd0);
`ifdef PROC_MEM_TIMEOUT_EN
        cyc_d       = cyc_q;
        timed_out_d = timed_out_q;
        cyc_nxt     = cyc_q + CYC_W'(1);
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    nop_d   = '0;
                    idx_d   = '0;
`ifdef PROC_MEM_TIMEOUT_EN
                    cyc_d       = '0;
                    timed_out_d = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                nop_d = nop_nxt;
                if (nop_nxt == NOP_W'(NOP_LIMIT)) begin
                    state_d = ST_DUMP;
                end
`ifdef PROC_MEM_TIMEOUT_EN
                cyc_d = cyc_nxt;
                // Watchdog checked last so a coincident NOP exit still reports timed_out
                if (cyc_nxt == CYC_W'(TIMEOUT)) begin
                    state_d     = ST_DUMP;
                    timed_out_d = 1'b1;
                end
`endif
            end
            ST_DUMP: begin
                if (dump_ready) begin
                    if (idx_q == 30'(DUMP_WORDS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 30'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        proc_rst_n_d = (state_d == ST_RUN);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            nop_q        <= '0;
            idx_q        <= '0;
            proc_rst_n_q <= 1'b0;
`ifdef PROC_MEM_TIMEOUT_EN
            cyc_q        <= '0;
            timed_out_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            nop_q        <= nop_d;
            idx_q        <= idx_d;
            proc_rst_n_q <= proc_rst_n_d;
`ifdef PROC_MEM_TIMEOUT_EN
            cyc_q        <= cyc_d;
            timed_out_q  <= timed_out_d;
`endif
        end
    end

    // Output decode and store gating
    always_comb begin
        proc_rst_n = proc_rst_n_q;
        dump_valid = (state_q == ST_DUMP);
        done       = (state_q == ST_DONE);
        dump_addr  = {idx_q, 2'b00};
`ifdef PROC_MEM_TIMEOUT_EN
        timed_out  = timed_out_q;
`else
        timed_out  = 1'b0;
`endif
        im_wr_en   = im_we && !rst && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        dm_wr_en   = data_wr && !rst && (state_q == ST_RUN);
    end

    be_byte_mem #(.DEPTH(MEM_DEPTH)) u_imem (
        .clk    (clk),
        .we     (im_wr_en),
        .waddr  (im_addr),
        .wdata  (im_wdata),
        .raddr0 (inst_addr),
        .raddr1 (data_addr),
        .raddr2 (dump_addr),
        .rdata0 (inst),
        .rdata1 (),
        .rdata2 ()
    );

    be_byte_mem #(.DEPTH(MEM_DEPTH)) u_dmem (
        .clk    (clk),
        .we     (dm_wr_en),
        .waddr  (data_addr),
        .wdata  (data_out),
        .raddr0 (data_addr),
        .raddr1 (dump_addr),
        .raddr2 (inst_addr),
        .rdata0 (data_in),
        .rdata1 (dump_data),
        .rdata2 ()
    );

endmodule

// File: doc/proc_mem_responder.md
# proc_mem_responder

Synthesizable memory-side responder for the single-cycle processor: serves instruction fetches from a byte-wide instruction store and loads/stores from a byte-wide data store. It sequences a run by holding the processor in reset until started and stopping on NOP count or watchdog. After the run it streams a data-memory dump over a valid/ready port. It replaces the behavioural memory and run-control logic around `processor` in system-level builds.

## Interface
- `MEM_DEPTH`, 1024, bytes per store (power of two)
- `DUMP_WORDS`, 22, 32-bit words streamed after the run, starting at byte 0
- `NOP_LIMIT`, 9, total fetched all-zero instructions that end the run
- `TIMEOUT`, 100, maximum run cycles (watchdog, see Configuration)

- `clk` in 1 — single clock, all state on rising edge
- `rst` in 1 — synchronous, active-high reset
- `start` in 1 — pulse; begins a run from IDLE or DONE
- `im_we` in 1 — instruction-store word write, honoured only in IDLE/DONE
- `im_addr` in 32 — byte address for `im_we`
- `im_wdata` in 32 — word for `im_we`, big-endian
- `proc_rst_n` out 1 — processor reset; low except in RUN
- `inst_addr` in 32 — processor fetch address
- `inst` out 32 — fetched word
- `data_addr` in 32 — processor load/store address
- `data_out` in 32 — processor store data
- `data_wr` in 1 — processor store enable
- `data_in` out 32 — load data to processor
- `dump_valid` out 1, `dump_ready` in 1 — dump handshake
- `dump_addr` out 32 — byte address of current dump word
- `dump_data` out 32 — current dump word
- `done` out 1 — high in DONE
- `timed_out` out 1 — run ended by watchdog

## Operation
- States: IDLE, RUN, DUMP, DONE.
- IDLE/DONE + `start` go to RUN. This clears the NOP count, cycle count and `timed_out`.
- In RUN, each cycle with `inst == 0` increments the NOP count.
- RUN goes to DUMP on the edge where the updated NOP count reaches `NOP_LIMIT`, or the updated cycle count reaches `TIMEOUT`.
- DUMP: word index i from 0.
  - `dump_valid=1`, `dump_addr=4*i`.
  - `dump_data` is the big-endian word at `4*i`.
  - On `dump_valid && dump_ready`, i increments.
  - Acceptance of word `DUMP_WORDS-1` goes to DONE.
- `start` in RUN/DUMP is ignored. `im_we` in RUN/DUMP is ignored.
- Reads (`inst`, `data_in`, `dump_data`) are combinational and big-endian: byte a → [31:24], a+1 → [23:16], a+2 → [15:8], a+3 → [7:0].
  - Each byte address is taken modulo `MEM_DEPTH`, so unaligned and wrapping accesses are legal.
- Stores write the same four bytes on the clock edge. They are honoured only in RUN.
- Stores in other states, and stores while `rst` is high, are dropped.
- Memories are not cleared by `rst`. Contents survive reset and re-runs.

## Timing
- Reset values:
  - state IDLE
  - `proc_rst_n=0`, `dump_valid=0`, `dump_addr=0`, `done=0`, `timed_out=0`
  - counters and index 0
- `proc_rst_n` is registered from state. It rises on the edge entering RUN and falls on the edge leaving RUN.
- Fetch and load have zero latency, matching the single-cycle core.
- Store-then-load at the same address: the new value is visible on the cycle after the store edge.
- Simultaneous NOP-limit and timeout on the same edge: go to DUMP with `timed_out=1`.
- Dump throughput is one word per cycle with `dump_ready` held high. `DUMP_WORDS` accepted words take `DUMP_WORDS` cycles. `dump_data` and `dump_addr` are stable while stalled.
- `rst` mid-RUN or mid-DUMP returns to IDLE next edge. The partial dump is abandoned and the processor is held in reset.
- `start` and `rst` together: `rst` wins.

## Configuration
- `PROC_MEM_TIMEOUT_EN` defined: the cycle counter (width ⌈log2(TIMEOUT+1)⌉) and watchdog exit are present. `timed_out` reflects a watchdog exit.
- Undefined: no cycle counter. The run ends only on `NOP_LIMIT`, and `timed_out` is tied 0.

## Structure
- Shared package `proc_mem_pkg` holds:
  - state enum (IDLE, RUN, DUMP, DONE)
  - byte/word width constants (8, 32)
  - default `MEM_DEPTH`
- One sub-module `be_byte_mem`: byte array with three combinational 32-bit big-endian read ports and one 32-bit write port with wrap.
  - Instantiated twice: the instruction store (write port driven by `im_*`) and the data store.
  - The instruction store's `data_addr` read port is unused.

## Test plan
- Load `0x20080005` at 0, zeros after; `start` → `proc_rst_n` rises next edge. 9 zero fetches → DUMP with `timed_out=0`.
- Core stores `0xDEADBEEF` to address 8 → dump word 2 is `0xDEADBEEF`, `dump_addr=8`.
- Load at `MEM_DEPTH-2` after writing bytes AA,BB there and CC,DD at 0,1 → `data_in = 0xAABBCCDD`.
- Infinite loop `0x08000000` with `PROC_MEM_TIMEOUT_EN` → DUMP after exactly 100 RUN cycles, `timed_out=1`.
- `dump_ready` toggled 1,0,0,1 → no word lost or duplicated; 22 words then `done=1`.
- `rst` asserted during dump word 5 → IDLE, `dump_valid=0`, `proc_rst_n=0`. Restart dumps memory unchanged from word 0.
